// File: rtl/alu_pipe.sv
// Pipelined ALU stage: valid/ready on both sides, registered result and flags,
// single-cycle logic/arith/shift ops and an iterative shift-add multiplier.
module alu_pipe #(
    parameter  int WIDTH = 32,
    parameter  int OP_W  = 6,
    localparam int SH_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  alu_op,
    input  logic [WIDTH-1:0] r2,
    input  logic [WIDTH-1:0] r3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r1,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    localparam logic [OP_W-1:0] OP_MOVE  = OP_W'(6'b010000);
    localparam logic [OP_W-1:0] OP_LWI   = OP_W'(6'b111011);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(6'b010010);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b110010);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(6'b010011);
    localparam logic [OP_W-1:0] OP_SUBI  = OP_W'(6'b110011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b100000);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(6'b010100);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b110100);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(6'b010101);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'b110101);
    localparam logic [OP_W-1:0] OP_LI    = OP_W'(6'b111001);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(6'b010110);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(6'b010111);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'(6'b011000);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'(6'b011001);
    localparam logic [OP_W-1:0] OP_MUL   = OP_W'(6'b011010);

    logic [0:0]       state_reg;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] r1_reg;
    logic             zero_reg;
    logic             neg_reg;
    logic             carry_reg;
    logic             ovf_reg;
    logic             out_valid_reg;

    logic             accept;
    logic [SH_W-1:0]  sh_amt;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic [WIDTH-1:0] sll_res;
    logic [WIDTH-1:0] srl_res;
    logic [WIDTH-1:0] sra_res;

    logic [WIDTH-1:0] op_res;
    logic             op_carry;
    logic             op_ovf;
    logic             op_keep;
    logic             op_mul;

    assign in_ready = !rst && (state_reg == ST_IDLE) && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;

    assign sh_amt  = r3[SH_W-1:0];
    assign add_sum = {1'b0, r2} + {1'b0, r3};
    // Subtraction as r2 + ~r3 + 1 so carry-out reads as "no borrow".
    assign sub_sum = {1'b0, r2} + {1'b0, ~r3} + {{WIDTH{1'b0}}, 1'b1};
    assign sll_res = r2 << sh_amt;
    assign srl_res = r2 >> sh_amt;
    assign sra_res = WIDTH'($signed(r2) >>> sh_amt);

    always_comb begin
        op_res   = '0;
        op_carry = 1'b0;
        op_ovf   = 1'b0;
        op_keep  = 1'b0;
        op_mul   = 1'b0;
        case (alu_op)
            OP_MOVE, OP_LWI: op_res = r2;
            OP_ADD, OP_ADDI: begin
                op_res   = add_sum[WIDTH-1:0];
                op_carry = add_sum[WIDTH];
                op_ovf   = (r2[WIDTH-1] == r3[WIDTH-1]) && (add_sum[WIDTH-1] != r2[WIDTH-1]);
            end
            OP_SUB, OP_SUBI, OP_BEQ: begin
                op_res   = sub_sum[WIDTH-1:0];
                op_carry = sub_sum[WIDTH];
                op_ovf   = (r2[WIDTH-1] != r3[WIDTH-1]) && (sub_sum[WIDTH-1] != r2[WIDTH-1]);
            end
            OP_OR, OP_ORI:   op_res = r2 | r3;
            OP_AND, OP_ANDI: op_res = r2 & r3;
            OP_LI:           op_res = r3;
            OP_XOR:          op_res = r2 ^ r3;
            OP_SLL:          op_res = sll_res;
            OP_SRL:          op_res = srl_res;
            OP_SRA:          op_res = sra_res;
            OP_MUL:          op_mul = 1'b1;
            default:         op_keep = 1'b1;
        endcase
    end

    assign acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            count_reg     <= '0;
            acc_reg       <= '0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            r1_reg        <= '0;
            zero_reg      <= 1'b1;
            neg_reg       <= 1'b0;
            carry_reg     <= 1'b0;
            ovf_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            // Drained beat clears here; a new result below takes precedence.
            if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        if (op_mul) begin
                            mcand_reg  <= r2;
                            mplier_reg <= r3;
                            acc_reg    <= '0;
                            count_reg  <= CNT_W'(WIDTH);
                            state_reg  <= ST_MUL;
                        end else begin
                            out_valid_reg <= 1'b1;
                            if (!op_keep) begin
                                r1_reg    <= op_res;
                                zero_reg  <= (op_res == '0);
                                neg_reg   <= op_res[WIDTH-1];
                                carry_reg <= op_carry;
                                ovf_reg   <= op_ovf;
                            end
                        end
                    end
                end
                ST_MUL: begin
                    acc_reg    <= acc_next;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    count_reg  <= count_reg - 1'b1;
                    if (count_reg == CNT_W'(1)) begin
                        r1_reg        <= acc_next;
                        zero_reg      <= (acc_next == '0);
                        neg_reg       <= acc_next[WIDTH-1];
                        carry_reg     <= 1'b0;
                        ovf_reg       <= 1'b0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign r1        = r1_reg;
    assign zero      = zero_reg;
    assign neg       = neg_reg;
    assign carry     = carry_reg;
    assign ovf       = ovf_reg;
    assign out_valid = out_valid_reg;
    assign busy      = (state_reg == ST_MUL);

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: driver pushes model results, monitor pops on each output beat.
module tb_alu_pipe;

    typedef struct packed {
        logic [31:0] r1;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  alu_op;
    logic [31:0] r2;
    logic [31:0] r3;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] r1;
    logic        zero;
    logic        neg;
    logic        carry;
    logic        ovf;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int bp_mode  = 0;
    res_t sb[$];
    res_t lst;

    alu_pipe #(.WIDTH(32), .OP_W(6)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .r2(r2), .r3(r3), .out_valid(out_valid),
        .out_ready(out_ready), .r1(r1), .zero(zero), .neg(neg),
        .carry(carry), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic res_t mk(input logic [31:0] v, input logic c, input logic o);
        res_t r;
        r.r1 = v;
        r.z  = (v == 32'd0);
        r.n  = v[31];
        r.c  = c;
        r.v  = o;
        return r;
    endfunction

    // Reference behaviour from the opcode table, using wide integer arithmetic.
    function automatic res_t model_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] u;
        longint      sr;
        res_t        r;
        r = lst;
        case (op)
            6'h10, 6'h3B: r = mk(a, 1'b0, 1'b0);
            6'h12, 6'h32: begin
                u  = 64'(a) + 64'(b);
                sr = longint'($signed(a)) + longint'($signed(b));
                r  = mk(u[31:0], u > 64'hFFFF_FFFF, (sr > 64'sd2147483647) || (sr < -64'sd2147483648));
            end
            6'h13, 6'h33, 6'h20: begin
                sr = longint'($signed(a)) - longint'($signed(b));
                r  = mk(a - b, a >= b, (sr > 64'sd2147483647) || (sr < -64'sd2147483648));
            end
            6'h14, 6'h34: r = mk(a | b, 1'b0, 1'b0);
            6'h15, 6'h35: r = mk(a & b, 1'b0, 1'b0);
            6'h39:        r = mk(b, 1'b0, 1'b0);
            6'h16:        r = mk(a ^ b, 1'b0, 1'b0);
            6'h17:        r = mk(a << b[4:0], 1'b0, 1'b0);
            6'h18:        r = mk(a >> b[4:0], 1'b0, 1'b0);
            6'h19:        r = mk(32'($signed(a) >>> b[4:0]), 1'b0, 1'b0);
            6'h1A: begin
                u = 64'(a) * 64'(b);
                r = mk(u[31:0], 1'b0, 1'b0);
            end
            default: r = lst;
        endcase
        lst = r;
        return r;
    endfunction

    task automatic model_reset();
        lst = mk(32'd0, 1'b0, 1'b0);
        sb.delete();
    endtask

    task automatic set_bp(input int m);
        bp_mode   = m;
        out_ready = (m != 2);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, output int waits);
        logic rdy;
        waits    = 0;
        in_valid = 1'b1;
        alu_op   = op;
        r2       = a;
        r3       = b;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            waits++;
        end while (!rdy && waits < 200);
        if (rdy) begin
            sb.push_back(model_op(op, a, b));
        end else begin
            failures++;
            checks++;
            $display("FAIL accept_timeout: op %h not accepted within %0d cycles", op, waits);
        end
        in_valid = 1'b0;
    endtask

    always begin
        @(posedge clk);
        #1;
        if (bp_mode == 0)      out_ready = 1'b1;
        else if (bp_mode == 1) out_ready = ($urandom_range(3) != 0);
        else                   out_ready = 1'b0;
    end

    // Monitor: pops one expected entry per delivered beat; checks stability while stalled.
    initial begin : monitor
        res_t cur;
        res_t prev;
        res_t exp;
        logic prev_stall;
        prev_stall = 1'b0;
        prev       = '0;
        forever begin
            @(negedge clk);
            cur = {r1, zero, neg, carry, ovf};
            if (rst) begin
                prev_stall = 1'b0;
            end else if (out_valid) begin
                if (prev_stall) chk("hold_stable", 64'(cur), 64'(prev));
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat: got %h expected none", cur);
                    end else begin
                        exp = sb.pop_front();
                        chk("result", 64'(cur), 64'(exp));
                    end
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev       = cur;
                end
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [5:0] ops [0:21] = '{6'h00, 6'h10, 6'h3B, 6'h12, 6'h32, 6'h13, 6'h33, 6'h20, 6'h14, 6'h34, 6'h15,
                               6'h35, 6'h39, 6'h16, 6'h17, 6'h18, 6'h19, 6'h3F, 6'h01, 6'h12, 6'h13, 6'h19};

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(5))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(40));
            default: return $urandom;
        endcase
    endfunction

    initial begin : main
        int w;
        int cnt;
        logic [5:0] op;
        rst = 1'b1; in_valid = 1'b0; alu_op = '0; r2 = '0; r3 = '0; out_ready = 1'b1;
        model_reset();

        // Reset state
        @(negedge clk);
        chk("rst_r1", 64'(r1), 64'd0);
        chk("rst_zero", 64'(zero), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("rst_in_ready2", 64'(in_ready), 64'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // ADD / SUB flags
        issue(6'h12, 32'h7FFF_FFFF, 32'd1, w);
        issue(6'h12, 32'hFFFF_FFFF, 32'd1, w);
        issue(6'h20, 32'd5, 32'd5, w);
        issue(6'h13, 32'd3, 32'd5, w);

        // Back-to-back with back-pressure
        issue(6'h16, 32'hA5A5_0F0F, 32'hFFFF_0000, w);
        chk("b2b_xor_wait", 64'(w), 64'd1);
        issue(6'h19, 32'h8000_0000, 32'd4, w);
        chk("b2b_sra_wait", 64'(w), 64'd1);
        issue(6'h39, 32'd0, 32'h1234_5678, w);
        chk("b2b_li_wait", 64'(w), 64'd1);
        set_bp(2);
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk); #1; set_bp(0);
        @(negedge clk);
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Multiply; a held in_valid during busy must not be accepted
        issue(6'h1A, 32'h0000_FFFF, 32'h0001_0001, w);
        in_valid = 1'b1; alu_op = 6'h12; r2 = 32'd1; r3 = 32'd1;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
            if (in_ready) chk("mul_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        chk("mul_busy_cycles", 64'(cnt), 64'd32);
        chk("mul_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;

        // Reset during multiply
        issue(6'h1A, 32'd1234, 32'd5678, w);
        repeat (9) begin @(posedge clk); #1; end
        chk("mul_busy_before_rst", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mulrst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("mulrst_busy", 64'(busy), 64'd0);
        chk("mulrst_out_valid", 64'(out_valid), 64'd0);
        chk("mulrst_r1", 64'(r1), 64'd0);
        @(posedge clk); #1;
        issue(6'h12, 32'd2, 32'd3, w);

        // NOOP and undefined opcodes keep the previous result
        issue(6'h12, 32'd3, 32'd4, w);
        issue(6'h00, 32'hDEAD_BEEF, 32'h1, w);
        issue(6'h3F, 32'hCAFE_F00D, 32'h2, w);

        // Randomized traffic with random back-pressure
        set_bp(1);
        for (int n = 0; n < 200; n++) begin
            op = ($urandom_range(15) == 0) ? 6'h1A : ops[$urandom_range(21)];
            issue(op, rnd_operand(), rnd_operand(), w);
            if ($urandom_range(3) == 0) begin @(posedge clk); #1; end
        end
        set_bp(0);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, clocked successor to the CPU's combinational ALU. It keeps the existing opcode map, and adds:
- a valid/ready handshake on both input and output,
- a registered result with a full flag set (zero, negative, carry, overflow),
- barrel shifts and XOR,
- an iterative shift-add multiplier.

It sits between the decode/register-read stage and writeback, and stalls the pipeline through back-pressure while a multiply runs or writeback is not ready.

## Interface
- `WIDTH`, 32: operand and result width (≥ 4, power of two).
- `OP_W`, 6: opcode width.
- `SH_W`, `$clog2(WIDTH)`: shift-amount width (derived, do not override).
- `clk`  in  1: clock. There is one clock; all state changes on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `in_valid`  in  1: an operation is offered.
- `in_ready`  out  1: the block accepts the offered operation this cycle.
- `alu_op`  in  `OP_W`: opcode.
- `r2`, `r3`  in  `WIDTH` each: operands.
- `out_valid`  out  1: `r1` and the flags hold a result.
- `out_ready`  in  1: the consumer takes the result this cycle.
- `r1`  out  `WIDTH`: result.
- `zero`, `neg`, `carry`, `ovf`  out  1 each: result flags.
- `busy`  out  1: a multiply is in progress.

## Operation
- **Transfers.** A transfer occurs when both valid and ready are high at a rising edge.
- **Opcodes,** with `r1` the result:
  - 000000 NOOP: `r1` and flags keep their previous values; the op still produces one `out_valid` beat.
  - 010000, 111011 MOVE/LWI: `r2`.
  - 010010, 110010 ADD: `r2 + r3`.
  - 010011, 110011, 100000 SUB/BEQ: `r2 − r3`.
  - 010100, 110100 OR.
  - 010101, 110101 AND.
  - 111001 LI: `r3`.
  - 010110 XOR.
  - 010111 SLL: `r2 << r3[SH_W-1:0]`.
  - 011000 SRL: logical right shift.
  - 011001 SRA: arithmetic right shift.
  - 011010 MUL: low `WIDTH` bits of `r2 × r3`, unsigned.
  - Any other code behaves as NOOP.
- **Flags.**
  - `zero` = (`r1` == 0).
  - `neg` = `r1[WIDTH-1]`.
  - ADD: `carry` = carry-out of the `WIDTH+1`-bit sum; `ovf` = signed overflow.
  - SUB: computed as `r2 + ~r3 + 1`; `carry` = carry-out of that sum (1 means no borrow); `ovf` = signed overflow.
  - All other ops, except NOOP: `carry` = 0 and `ovf` = 0. NOOP keeps all flags.
- **State machine.**
  - IDLE: on acceptance of a non-MUL op, latch the result and flags and set `out_valid`, staying in IDLE. On acceptance of MUL, latch the multiplicand, multiplier and a zeroed accumulator, set the counter to `WIDTH`, and go to MUL.
  - MUL: each cycle, if the multiplier LSB is 1, add the multiplicand to the accumulator; shift the multiplicand left and the multiplier right; decrement the counter. On the cycle the counter reaches 0, write the accumulator to `r1`, set the flags, set `out_valid`, and go to IDLE.
- **`in_ready`:**
  - `in_ready` = !`rst` && state == IDLE && (!`out_valid` || `out_ready`).
  - A result can therefore be drained and a new op accepted on the same edge, giving one op per cycle for non-MUL ops.
- **`out_valid`:**
  - It falls on an edge where `out_ready` is high and no new result is produced.
  - `r1` and the flags stay stable while `out_valid` is high and `out_ready` is low.
- **`busy`** = (state == MUL).
- **Ignored inputs.** `alu_op`, `r2` and `r3` are ignored whenever `in_ready` is low.

## Timing
- **Reset.** When `rst` is high at an edge:
  - state becomes IDLE, and the counter and accumulator are cleared;
  - `r1` = 0, `zero` = 1, and `neg` = `carry` = `ovf` = 0;
  - `out_valid` = 0, `busy` = 0, and `in_ready` = 0 while `rst` is high.
- **Reset mid-multiply** aborts the multiply; no result is produced.
- **Non-MUL latency.** For an op accepted at edge k, `out_valid` is high after edge k. Sustained throughput is 1 op per cycle when `out_ready` = 1.
- **MUL latency.** For a MUL accepted at edge k, `busy` is high after edge k and `out_valid` is high after edge k + `WIDTH`. `in_ready` is low from edge k until edge k + `WIDTH`.
- **Back-pressure.** A result with `out_ready` = 0 holds indefinitely, and `in_ready` stays low until it is drained.
- **Shift amounts.** Only `r3[SH_W-1:0]` is used. A shift by 0 returns `r2`.
- **Wrap-around.** ADD, SUB and MUL wrap modulo 2^`WIDTH`.

## Test plan
1. **Reset state.** Drive `rst` = 1 for 2 cycles, then release → `r1` = 0, `zero` = 1, `out_valid` = 0, `in_ready` = 0 during reset and 1 on the first cycle after it.
2. **ADD and SUB flags, `WIDTH` = 32.**
   - ADD 0x7FFFFFFF + 1 → `r1` = 0x80000000, `neg` = 1, `ovf` = 1, `carry` = 0.
   - ADD 0xFFFFFFFF + 1 → `r1` = 0, `zero` = 1, `carry` = 1.
   - SUB 5 − 5 (opcode 100000) → `zero` = 1, `carry` = 1.
3. **Back-to-back ops with back-pressure.** Issue XOR, SRA and LI on consecutive cycles with `out_ready` = 1, using SRA with `r2` = 0x80000000 and `r3` = 4, then hold `out_ready` = 0 for 3 cycles:
   - one result per cycle, and SRA gives 0xF8000000;
   - the final result holds stable;
   - `in_ready` = 0 until `out_ready` returns to 1.
4. **Multiply.** MUL 0x0000FFFF × 0x00010001 → `busy` for 32 cycles, then `r1` = 0xFFFFFFFF with `out_valid` on the cycle after edge k + 32. `in_valid` held high during `busy` is not accepted.
5. **Reset during multiply.** Assert `rst` at cycle 10 of a MUL → no `out_valid`, `busy` = 0, `r1` = 0. The next ADD 2 + 3 gives 5.
6. **NOOP and undefined opcodes.** After ADD gives 7, issue NOOP and then opcode 111111 → each produces one `out_valid` beat with `r1` = 7 and flags unchanged.
